// File: rtl/vend_controller.sv
// Vending-machine transaction controller: accumulates coin credit, dispenses one item
// when credit covers the price and returns change as a train of nickel pulses.
module vend_controller #(
    parameter int unsigned PRICE      = 65,
    parameter int unsigned MAX_CREDIT = 100,
    parameter int unsigned CHANGE_GAP = 2,
    parameter int unsigned W          = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         coin_5,
    input  logic         coin_10,
    input  logic         coin_25,
    input  logic         buy,
    input  logic         cancel,
    output logic [W-1:0] credit,
    output logic [1:0]   state,
    output logic         dispense,
    output logic         change_out,
    output logic         coin_reject,
    output logic         need_more,
    output logic         busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCredit = 2'd1,
        StVend   = 2'd2,
        StChange = 2'd3
    } state_e;

    localparam int unsigned GW        = $clog2(CHANGE_GAP);
    localparam logic [W:0]  PriceW    = (W+1)'(PRICE);
    localparam logic [W:0]  MaxW      = (W+1)'(MAX_CREDIT);
    localparam logic [GW-1:0] GapLoad = GW'(CHANGE_GAP - 1);
    localparam logic [W-1:0] Nickel   = W'(5);

    state_e        state_q, state_d;
    logic [W-1:0]  credit_q, credit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          dispense_q, dispense_d;
    logic          change_q, change_d;
    logic          reject_q, reject_d;
    logic          need_more_q, need_more_d;
    logic          busy_q, busy_d;

    logic          accepting, any_coin, cancel_ok, buy_ok, coin_ok;
    logic [W:0]    coin_sum, credit_sum;

    // Request decode shared by the next-state and output logic.
    assign accepting  = (state_q == StIdle) || (state_q == StCredit);
    assign any_coin   = coin_5 || coin_10 || coin_25;
    assign coin_sum   = (coin_5  ? (W+1)'(5)  : '0) +
                        (coin_10 ? (W+1)'(10) : '0) +
                        (coin_25 ? (W+1)'(25) : '0);
    assign credit_sum = {1'b0, credit_q} + coin_sum;
    assign cancel_ok  = accepting && cancel && (credit_q != '0);
    assign buy_ok     = accepting && buy && !cancel_ok && ({1'b0, credit_q} >= PriceW);
    assign coin_ok    = accepting && any_coin && !cancel_ok && !buy_ok && (credit_sum <= MaxW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            credit_q    <= '0;
            gap_q       <= '0;
            dispense_q  <= 1'b0;
            change_q    <= 1'b0;
            reject_q    <= 1'b0;
            need_more_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            gap_q       <= gap_d;
            dispense_q  <= dispense_d;
            change_q    <= change_d;
            reject_q    <= reject_d;
            need_more_q <= need_more_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StCredit: begin
                if (cancel_ok)    state_d = StChange;
                else if (buy_ok)  state_d = StVend;
                else if (coin_ok) state_d = StCredit;
            end
            StVend:   state_d = (credit_q != '0) ? StChange : StIdle;
            StChange: state_d = (credit_q == '0) ? StIdle : StChange;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        credit_d    = credit_q;
        gap_d       = gap_q;
        dispense_d  = 1'b0;
        change_d    = 1'b0;
        reject_d    = 1'b0;
        need_more_d = 1'b0;
        unique case (state_q)
            StIdle, StCredit: begin
                reject_d    = any_coin && !coin_ok;
                need_more_d = buy && !cancel_ok && !buy_ok;
                if (cancel_ok) begin
                    credit_d = credit_q - Nickel;
                    change_d = 1'b1;
                    gap_d    = GapLoad;
                end else if (buy_ok) begin
                    credit_d   = credit_q - W'(PRICE);
                    dispense_d = 1'b1;
                end else if (coin_ok) begin
                    credit_d = credit_sum[W-1:0];
                end
            end
            StVend: begin
                reject_d = any_coin;
                if (credit_q != '0) begin
                    credit_d = credit_q - Nickel;
                    change_d = 1'b1;
                    gap_d    = GapLoad;
                end
            end
            StChange: begin
                reject_d = any_coin;
                // gap_q counts down the idle cycles between nickel pulses.
                if (credit_q == '0) begin
                    gap_d = '0;
                end else if (gap_q == '0) begin
                    credit_d = credit_q - Nickel;
                    change_d = 1'b1;
                    gap_d    = GapLoad;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == StVend) || (state_d == StChange);
    end

    assign credit      = credit_q;
    assign state       = state_q;
    assign dispense    = dispense_q;
    assign change_out  = change_q;
    assign coin_reject = reject_q;
    assign need_more   = need_more_q;
    assign busy        = busy_q;

endmodule

// File: doc/vend_controller.md
# vend_controller

Vending-machine transaction controller. It sits directly downstream of the per-button debounce/edge-detect stages and consumes their single-cycle pulses: coin inserts (5/10/25), buy and cancel. It accumulates credit, dispenses one item when credit covers the price, and returns change as a train of nickel pulses. All outputs are registered.

## Interface
- PRICE, 65: item price in cents; multiple of 5, ≤ MAX_CREDIT.
- MAX_CREDIT, 100: credit ceiling in cents; multiple of 5, < 2^W.
- CHANGE_GAP, 2: period in cycles between change pulses; ≥ 2.
- W, 8: credit width.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs.
- coin_5, coin_10, coin_25  in  1 each  single-cycle insert pulses.
- buy  in  1  single-cycle purchase request.
- cancel  in  1  single-cycle refund request.
- credit  out  W  current credit in cents.
- state  out  2  IDLE=0, CREDIT=1, VEND=2, CHANGE=3.
- dispense  out  1  one-cycle item release pulse.
- change_out  out  1  one pulse per 5 cents returned.
- coin_reject  out  1  one-cycle pulse; the coin(s) in the previous cycle were not credited.
- need_more  out  1  one-cycle pulse; the buy in the previous cycle was refused for insufficient credit.
- busy  out  1  high while state is VEND or CHANGE.

## Operation
- Reset values: credit=0, state=IDLE. dispense, change_out, coin_reject, need_more and busy are all 0. The gap counter is 0.
- IDLE and CREDIT accept requests with priority cancel > buy > coins.
  - cancel with credit>0: go to CHANGE and refund the full credit.
  - cancel with credit=0: no effect, except coins in the same cycle are still accepted.
  - buy with credit≥PRICE: go to VEND, pulse dispense, credit -= PRICE.
  - buy with credit<PRICE: pulse need_more, state unchanged, coins in the same cycle are processed normally.
  - Coins (no accepted buy or cancel): sum all asserted coin inputs in the same cycle.
    - If credit+sum ≤ MAX_CREDIT: credit += sum and state = CREDIT.
    - Otherwise: credit is unchanged and coin_reject pulses (all-or-nothing).
  - Any coin arriving in the same cycle as an accepted buy or cancel is rejected with a coin_reject pulse.
- VEND lasts exactly one cycle. Next state is CHANGE if credit>0, else IDLE.
- CHANGE:
  - Each pulse of change_out decrements credit by 5 on the same edge.
  - Pulses repeat every CHANGE_GAP cycles while credit>0.
  - On the edge after credit reaches 0, go to IDLE. No trailing gap is required.
- In VEND and CHANGE, all coin inputs produce coin_reject; buy and cancel are ignored silently.
- Arithmetic is unsigned W-bit. The sum is computed in W+1 bits to avoid wrap. Credit never exceeds MAX_CREDIT and never underflows.
- Reset asserted mid-operation clears everything immediately; any pending change is lost.

## Timing
- Coin pulse in cycle N: credit is updated in N+1. A reject shows as coin_reject=1 in N+1.
- Accepted buy in cycle N:
  - N+1: state=VEND, dispense=1, credit=old−PRICE, busy=1.
  - N+2: state=CHANGE with change_out=1 and credit−5 (if credit remained), else IDLE.
- Change pulses fall at N+2, N+2+CHANGE_GAP, … . change_out is never high in two consecutive cycles.
- Accepted cancel in cycle N: N+1 is state=CHANGE with the first change_out=1.
- busy reflects the registered state. It drops in the first IDLE cycle.
- Throughput: a new request is accepted no earlier than the first IDLE cycle after a transaction.

## Test plan
- Reset: hold reset=0 mid-CHANGE → all outputs 0 asynchronously; after release, state=IDLE and credit=0.
- Exact purchase: 25,25,10,5 → credit 65; buy → dispense for 1 cycle at N+1, credit 0, IDLE at N+2, no change_out.
- Purchase with change: 25,25,25 (75); buy → dispense at N+1, change_out at N+2 and N+4, credit 10→5→0, IDLE at N+5.
- Cancel: 10,5 then cancel → change_out ×3 spaced by CHANGE_GAP, credit back to 0; cancel at credit 0 → no response.
- Saturation and simultaneity: credit 90; coin_10 and coin_25 in one cycle → coin_reject, credit stays 90; coin_10 alone → credit 100; coin_5 → rejected.
- Priority and lockout: buy and coin_25 in the same cycle at credit 70 → dispense plus coin_reject; coin during CHANGE → coin_reject, no credit change; buy at credit 40 → need_more only.
